// File: rtl/io_bridge_if.sv
// CPU-side bus of the IO bridge: word address, write strobe, write data,
// read data back to the CPU and the hardware interrupt vector.
interface io_bridge_if;
    logic [29:0] Praddr;
    logic        WEcpu;
    logic [31:0] PrDout;
    logic [31:0] PrDin;
    logic [5:0]  HWint;

    // Bridge side: sees CPU requests, returns read data and interrupts.
    modport slave (
        input  Praddr,
        input  WEcpu,
        input  PrDout,
        output PrDin,
        output HWint
    );

    // CPU side: issues requests, consumes read data and interrupts.
    modport master (
        output Praddr,
        output WEcpu,
        output PrDout,
        input  PrDin,
        input  HWint
    );
endinterface

// File: rtl/io_bridge.sv
// io_bridge: decodes CPU accesses onto a 3-word timer window, an input-capture
// register and an output register. Reads are combinational (same cycle);
// writes take effect on the rising edge and are visible the next cycle.
// Optional feature: define IO_BRIDGE_ADDR_ERR_EN to build the sticky
// unmapped-write flag addr_err; otherwise addr_err is tied to 0.
module io_bridge #(
    parameter logic [31:0] TIMER_BASE = 32'h0000_7F00,
    parameter logic [31:0] IN32_ADDR  = 32'h0000_7F10,
    parameter logic [31:0] OUT32_ADDR = 32'h0000_7F20
) (
    input  logic               clk,
    input  logic               rst,
    io_bridge_if.slave         cpu,
    input  logic [31:0]        timer_rd,
    input  logic               timer_irq,
    input  logic [31:0]        in32_pin,
    output logic [1:0]         dev_addr,
    output logic [31:0]        dev_writeData,
    output logic [2:0]         we,
    output logic [31:0]        output_out32,
    output logic               addr_err
);

    logic [31:0] w_byte_addr;
    logic [31:0] w_timer_off;
    logic        w_hit_timer;
    logic        w_hit_in32;
    logic        w_hit_out32;
    logic [31:0] r_out32;
    logic [31:0] r_in32;

    // Full byte address; the timer window is matched by offset so the
    // compare cannot wrap and 0xC past the base falls outside it.
    assign w_byte_addr = {cpu.Praddr, 2'b00};
    assign w_timer_off = w_byte_addr - TIMER_BASE;
    assign w_hit_timer = (w_timer_off < 32'd12);
    assign w_hit_in32  = (w_byte_addr == IN32_ADDR);
    assign w_hit_out32 = (w_byte_addr == OUT32_ADDR);

    assign dev_addr      = cpu.Praddr[1:0];
    assign dev_writeData = cpu.PrDout;
    assign output_out32  = r_out32;
    assign cpu.HWint     = {5'b00000, timer_irq};

    // Write enables and read mux; hits are mutually exclusive so at most
    // one enable is high and unmapped addresses read as zero.
    always_comb begin
        we        = 3'b000;
        cpu.PrDin = 32'h0;
        if (w_hit_timer) begin
            we[0]     = cpu.WEcpu;
            cpu.PrDin = timer_rd;
        end else if (w_hit_in32) begin
            we[2]     = cpu.WEcpu;
            cpu.PrDin = r_in32;
        end else if (w_hit_out32) begin
            we[1]     = cpu.WEcpu;
            cpu.PrDin = r_out32;
        end
    end

    // Output register: loaded from CPU write data when selected.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out32 <= 32'h0;
        end else if (we[1]) begin
            r_out32 <= cpu.PrDout;
        end
    end

    // Input capture: a CPU write here samples the pins; write data is ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_in32 <= 32'h0;
        end else if (we[2]) begin
            r_in32 <= in32_pin;
        end
    end

`ifdef IO_BRIDGE_ADDR_ERR_EN
    logic w_unmapped;
    logic r_addr_err;

    assign w_unmapped = !(w_hit_timer || w_hit_in32 || w_hit_out32);
    assign addr_err   = r_addr_err;

    // Sticky flag: any write to an unmapped address sets it until reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr_err <= 1'b0;
        end else if (cpu.WEcpu && w_unmapped) begin
            r_addr_err <= 1'b1;
        end
    end
`else
    assign addr_err = 1'b0;
`endif

endmodule

// File: tb/tb_io_bridge.sv
// Scoreboard bench for io_bridge: stimulus queues expected values tagged with
// the cycle they apply to; a monitor on the falling edge pops and compares.
module tb_io_bridge;

  logic        clk;
  logic        rst;
  logic [31:0] timer_rd;
  logic        timer_irq;
  logic [31:0] in32_pin;
  logic [1:0]  dev_addr;
  logic [31:0] dev_writeData;
  logic [2:0]  we;
  logic [31:0] output_out32;
  logic        addr_err;

  io_bridge_if bus ();

  io_bridge dut (
    .clk           (clk),
    .rst           (rst),
    .cpu           (bus.slave),
    .timer_rd      (timer_rd),
    .timer_irq     (timer_irq),
    .in32_pin      (in32_pin),
    .dev_addr      (dev_addr),
    .dev_writeData (dev_writeData),
    .we            (we),
    .output_out32  (output_out32),
    .addr_err      (addr_err)
  );

  localparam int S_PRDIN = 0;
  localparam int S_WE    = 1;
  localparam int S_OUT32 = 2;
  localparam int S_HWINT = 3;
  localparam int S_DADDR = 4;
  localparam int S_AERR  = 5;
  localparam int S_WDATA = 6;

`ifdef IO_BRIDGE_ADDR_ERR_EN
  localparam logic AERR_ON = 1'b1;
`else
  localparam logic AERR_ON = 1'b0;
`endif

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   done = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] get_sig(input int sel);
    case (sel)
      S_PRDIN: return bus.PrDin;
      S_WE:    return {29'h0, we};
      S_OUT32: return output_out32;
      S_HWINT: return {26'h0, bus.HWint};
      S_DADDR: return {30'h0, dev_addr};
      S_AERR:  return {31'h0, addr_err};
      default: return dev_writeData;
    endcase
  endfunction

  initial begin
    while (!done) begin
      @(negedge clk);
      for (int i = 0; i < q.size(); ) begin
        if (q[i].cyc <= cyc) begin
          logic [31:0] act;
          act = get_sig(q[i].sel);
          n_checks++;
          if (q[i].cyc != cyc || act !== q[i].exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)",
                     q[i].name, act, q[i].exp, cyc);
          end
          q.delete(i);
        end else begin
          i++;
        end
      end
    end
  end

  task automatic expect_at(input int ofs, input int sel, input logic [31:0] e,
                           input string name);
    exp_t x;
    x.cyc  = cyc + ofs;
    x.sel  = sel;
    x.exp  = e;
    x.name = name;
    q.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_set(input logic [31:0] byte_addr, input logic wr,
                         input logic [31:0] data);
    bus.Praddr = byte_addr[31:2];
    bus.WEcpu  = wr;
    bus.PrDout = data;
  endtask

  initial begin
    rst       = 1'b0;
    timer_rd  = 32'h0;
    timer_irq = 1'b0;
    in32_pin  = 32'h0;
    bus_set(32'h7F20, 1'b0, 32'h0);

    step();
    expect_at(0, S_OUT32, 32'h0, "reset_out32");
    expect_at(0, S_PRDIN, 32'h0, "reset_prdin");
    expect_at(0, S_AERR,  32'h0, "reset_aerr");
    expect_at(0, S_WE,    32'h0, "reset_we");

    step();
    rst = 1'b1;

    step();
    bus_set(32'h7F20, 1'b1, 32'h1234_5678);
    expect_at(0, S_WE,    32'h2,          "out32_we");
    expect_at(0, S_WDATA, 32'h1234_5678,  "out32_wdata");
    expect_at(0, S_PRDIN, 32'h0,          "out32_pre_read");
    expect_at(1, S_OUT32, 32'h1234_5678,  "out32_value");
    expect_at(1, S_PRDIN, 32'h1234_5678,  "out32_readback");
    step();
    bus_set(32'h7F20, 1'b0, 32'h0);

    step();
    in32_pin = 32'hABAB_1212;
    bus_set(32'h7F10, 1'b1, 32'hDEAD_BEEF);
    expect_at(0, S_WE,    32'h4,         "in32_we");
    expect_at(0, S_PRDIN, 32'h0,         "in32_pre_read");
    expect_at(1, S_PRDIN, 32'hABAB_1212, "in32_read");
    expect_at(2, S_PRDIN, 32'hABAB_1212, "in32_hold");
    step();
    bus_set(32'h7F10, 1'b0, 32'h0);
    in32_pin = 32'h0;
    step();

    step();
    timer_rd = 32'h55;
    bus_set(32'h7F04, 1'b1, 32'h0);
    expect_at(0, S_WE,    32'h1,  "timer4_we");
    expect_at(0, S_DADDR, 32'h1,  "timer4_daddr");
    expect_at(0, S_PRDIN, 32'h55, "timer4_read");
    #1;
    n_checks++;
    if (bus.PrDin !== 32'h55) begin
      n_errors++;
      $display("FAIL timer4_read_direct: got 0x%08h expected 0x00000055", bus.PrDin);
    end
    step();
    timer_rd = 32'h99;
    bus_set(32'h7F08, 1'b1, 32'h0);
    expect_at(0, S_WE,    32'h1,  "timer8_we");
    expect_at(0, S_DADDR, 32'h2,  "timer8_daddr");
    expect_at(0, S_PRDIN, 32'h99, "timer8_read");
    step();
    bus_set(32'h7F0C, 1'b1, 32'h0);
    expect_at(0, S_WE,    32'h0, "timerC_we");
    expect_at(0, S_PRDIN, 32'h0, "timerC_read");
    expect_at(1, S_AERR,  {31'h0, AERR_ON}, "timerC_aerr");

    step();
    bus_set(32'h7F30, 1'b1, 32'hFFFF_FFFF);
    expect_at(0, S_WE,    32'h0,          "unmapped_we");
    expect_at(0, S_PRDIN, 32'h0,          "unmapped_read");
    expect_at(1, S_OUT32, 32'h1234_5678,  "unmapped_out32_hold");
    expect_at(1, S_AERR,  {31'h0, AERR_ON}, "unmapped_aerr");

    step();
    bus_set(32'h7F20, 1'b1, 32'hCAFE_F00D);
    timer_irq = 1'b1;
    expect_at(0, S_WE,    32'h2,          "out32b_we");
    expect_at(0, S_HWINT, 32'h1,          "hwint_on");
    expect_at(1, S_OUT32, 32'hCAFE_F00D,  "out32b_value");
    expect_at(1, S_AERR,  {31'h0, AERR_ON}, "aerr_sticky");
    #1;
    n_checks++;
    if (we !== 3'b010) begin
      n_errors++;
      $display("FAIL out32b_we_direct: got %b expected 010", we);
    end
    n_checks++;
    if (bus.HWint !== 6'b000001) begin
      n_errors++;
      $display("FAIL hwint_on_direct: got %b expected 000001", bus.HWint);
    end
    step();
    bus_set(32'h7F20, 1'b0, 32'h0);
    timer_irq = 1'b0;
    expect_at(0, S_HWINT, 32'h0,         "hwint_off");
    expect_at(0, S_PRDIN, 32'hCAFE_F00D, "out32b_readback");

    step();
    bus_set(32'h7F20, 1'b1, 32'h7777_7777);
    rst = 1'b0;
    expect_at(0, S_OUT32, 32'h0, "rst_async_out32");
    expect_at(0, S_AERR,  32'h0, "rst_async_aerr");
    expect_at(1, S_OUT32, 32'h0, "rst_write_lost");
    #1;
    n_checks++;
    if (output_out32 !== 32'h0) begin
      n_errors++;
      $display("FAIL rst_async_direct: got 0x%08h expected 0x00000000", output_out32);
    end
    step();
    step();
    rst = 1'b1;
    bus_set(32'h7F10, 1'b0, 32'h0);
    expect_at(0, S_PRDIN, 32'h0, "rst_in32_cleared");

    step();
    bus_set(32'h7F20, 1'b1, 32'h0000_0011);
    expect_at(1, S_OUT32, 32'h0000_0011, "post_rst_write");
    step();
    bus_set(32'h7F20, 1'b0, 32'h0);

    repeat (3) step();
    done = 1;
    @(negedge clk);
    #1;
    while (q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: never checked (due cycle %0d)", q[0].name, q[0].cyc);
      void'(q.pop_front());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/io_bridge.md
IO_BRIDGE -- requirements
Module: io_bridge

Interface
REQ-001 SHALL have parameter TIMER_BASE, default 32'h0000_7F00, byte base of the 3-word timer window (0x7F00..0x7F0B).
REQ-002 SHALL have parameter IN32_ADDR, default 32'h0000_7F10, byte address of the input-capture register.
REQ-003 SHALL have parameter OUT32_ADDR, default 32'h0000_7F20, byte address of the output register.
REQ-004 SHALL have ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- Praddr  in  30  CPU word address [31:2].
- WEcpu  in  1  CPU write strobe.
- PrDout  in  32  CPU write data.
- timer_rd  in  32  timer read data.
- timer_irq  in  1  timer interrupt request.
- in32_pin  in  32  external input bus.
- PrDin  out  32  read data to CPU.
- HWint  out  6  [7:2] hardware interrupt vector to CPU.
- dev_addr  out  2  [3:2] device register select.
- dev_writeData  out  32  device write data.
- we  out  3  one-hot write enables: [2] in32, [1] out32, [0] timer.
- output_out32  out  32  output register value.
- addr_err  out  1  sticky unmapped-write flag.

Function
REQ-005 SHALL decode the full byte address {Praddr,2'b00}; timer hit = TIMER_BASE..TIMER_BASE+8 (word offsets 0,1,2 only; +0xC unmapped); in32 hit = IN32_ADDR; out32 hit = OUT32_ADDR; all else unmapped.
REQ-006 SHALL drive dev_addr = Praddr[3:2] and dev_writeData = PrDout combinationally.
REQ-007 SHALL drive we[0]/we[2]/we[1] = WEcpu AND timer/in32/out32 hit respectively; at most one bit high; all 0 when WEcpu=0 or unmapped.
REQ-008 SHALL drive PrDin combinationally, same cycle: timer hit -> timer_rd; in32 hit -> in32 register; out32 hit -> output_out32; unmapped -> 32'h0.
REQ-009 SHALL load the out32 register with PrDout on the rising edge when we[1]=1, else hold; output_out32 = register.
REQ-010 SHALL capture in32_pin into the in32 register on the rising edge when we[2]=1 (CPU write to IN32_ADDR is a capture command; PrDout ignored), else hold.
REQ-011 SHALL make a captured/written value visible on PrDin/output_out32 from the cycle after the edge (one-cycle write latency, zero-cycle read latency).
REQ-012 SHALL drive HWint = {5'b00000, timer_irq} combinationally.
REQ-013 SHALL ignore Praddr/PrDout/WEcpu X-free glitches between edges; only rising-edge state changes.

Reset
REQ-014 SHALL, while rst=0, asynchronously clear out32 register, in32 register and addr_err to 0; combinational outputs follow inputs throughout.
REQ-015 SHALL resume normal operation on the first rising edge after rst returns to 1; a write coinciding with reset assertion SHALL be lost.

Configuration
REQ-016 SHALL compile the unmapped-access checker only when IO_BRIDGE_ADDR_ERR_EN is defined: addr_err set on a rising edge with WEcpu=1 and unmapped address (including TIMER_BASE+0xC), held until reset.
REQ-017 SHALL, without IO_BRIDGE_ADDR_ERR_EN, tie addr_err to 0 and keep the port present.

Verification
REQ-018 Write 0x1234_5678 to 0x7F20 -> we=3'b010 that cycle; output_out32 and PrDin (addr 0x7F20) = 0x1234_5678 next cycle.
REQ-019 in32_pin=0xABAB_1212, write any data to 0x7F10 -> we=3'b100; read 0x7F10 next cycle returns 0xABAB_1212; changing pin to 0 without write leaves read at 0xABAB_1212.
REQ-020 Address 0x7F04, WEcpu=1, timer_rd=0x55 -> we=3'b001, dev_addr=2'b01, PrDin=0x55; address 0x7F0C -> we=0, PrDin=0.
REQ-021 timer_irq=1 -> HWint=6'b000001; timer_irq=0 -> HWint=0.
REQ-022 With IO_BRIDGE_ADDR_ERR_EN: write to 0x7F30 -> addr_err=1 and stays 1 across later valid writes; rst=0 clears it; without macro addr_err stays 0.
REQ-023 Assert rst=0 mid-operation after REQ-018 -> output_out32=0 immediately, before any clock edge.
